// File: rtl/psum_pkg.sv
// Shared FP32 definitions for the partial-sum accumulator.
// Holds the single-precision field widths, exponent bias, the +0/+inf
// encodings and a packed view of an FP32 word used by the adder.
package psum_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
    localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp32_t;

endpackage

// File: rtl/fp32_add_rz.sv
// Combinational FP32 adder, round toward zero.
// Denormal operands are read as zero, results below the normal range
// flush to +0, exact cancellation yields +0, exponent overflow yields a
// signed infinity. NaN/inf operands produce an unspecified value.
// Ports:
//   i_a, i_b : operands
//   o_sum    : truncated sum
module fp32_add_rz
    import psum_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    fp32_t       w_x;          // operand with the larger magnitude
    fp32_t       w_y;          // operand with the smaller magnitude
    logic [23:0] w_mx;
    logic [23:0] w_my;
    logic [7:0]  w_d;
    logic [26:0] w_my_full;
    logic [26:0] w_shifted;
    logic [26:0] w_lost;
    logic        w_sticky;
    logic        w_eff_sub;
    logic [27:0] w_mx_e;
    logic [27:0] w_my_e;
    logic [27:0] w_sum;
    logic [4:0]  w_lz;
    logic [26:0] w_norm;
    logic [8:0]  w_exp_inc;

    // Index of the leading one counted from bit 26; 27 when the vector is zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // Align, add/subtract and normalize; three extra bits (guard, round,
    // sticky) keep truncation exact when the smaller operand is subtracted.
    always_comb begin
        if (i_b[30:0] > i_a[30:0]) begin
            w_x = fp32_t'(i_b);
            w_y = fp32_t'(i_a);
        end else begin
            w_x = fp32_t'(i_a);
            w_y = fp32_t'(i_b);
        end

        w_mx = (w_x.exp == 8'd0) ? 24'd0 : {1'b1, w_x.man};
        w_my = (w_y.exp == 8'd0) ? 24'd0 : {1'b1, w_y.man};
        w_d  = w_x.exp - w_y.exp;

        w_my_full = {w_my, 3'b000};
        if (w_d >= 8'd27) begin
            w_shifted = 27'd0;
            w_lost    = 27'd0;
            w_sticky  = |w_my;
        end else begin
            w_shifted = w_my_full >> w_d;
            w_lost    = w_my_full << (8'd27 - w_d);
            w_sticky  = |w_lost;
        end

        w_eff_sub = w_x.sign ^ w_y.sign;
        w_mx_e    = {1'b0, w_mx, 3'b000};
        w_my_e    = {1'b0, w_shifted[26:1], w_shifted[0] | w_sticky};
        w_sum     = w_eff_sub ? (w_mx_e - w_my_e) : (w_mx_e + w_my_e);

        w_lz      = lzc27(w_sum[26:0]);
        w_norm    = w_sum[26:0] << w_lz;
        w_exp_inc = {1'b0, w_x.exp} + 9'd1;

        o_sum = FP_POS_ZERO;
        if (w_sum == 28'd0) begin
            o_sum = FP_POS_ZERO;
        end else if (w_sum[27]) begin
            // Carry out of the hidden bit: shift right one place.
            if (w_exp_inc >= {1'b0, FP_EXP_MAX}) begin
                o_sum = {w_x.sign, FP_POS_INF[30:0]};
            end else begin
                o_sum = {w_x.sign, w_exp_inc[7:0], w_sum[26:4]};
            end
        end else if ({1'b0, w_x.exp} <= {4'd0, w_lz}) begin
            // Normalizing would leave the normal range: flush.
            o_sum = FP_POS_ZERO;
        end else begin
            o_sum = {w_x.sign, w_x.exp - {3'd0, w_lz}, w_norm[25:3]};
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Multi-channel FP32 partial-sum accumulator.
// Stage A registers the selected lane of an accepted word; stage B adds it
// to the channel accumulator and, on a last word, emits the sum and clears
// the channel. Results are held until taken by the consumer.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : input handshake; val (N lanes), ind, ch, last
//   clear                : synchronous zero of all channels, flushes A/B
//   out_valid/out_ready  : result handshake; out_ch, psum
//   busy                 : stage B holds a valid word
module psum_accumulator
    import psum_pkg::*;
#(
    parameter  int N          = 4,
    parameter  int VALUE_SIZE = 32,
    parameter  int INDEX_SIZE = 7,
    parameter  int NUM_CH     = 8,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*VALUE_SIZE-1:0] val,
    input  logic [INDEX_SIZE-1:0]   ind,
    input  logic [CH_W-1:0]         ch,
    input  logic                    last,
    input  logic                    clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic [VALUE_SIZE-1:0]   psum,
    output logic                    busy
);

    logic                  r_a_valid;
    logic [VALUE_SIZE-1:0] r_a_val;
    logic [CH_W-1:0]       r_a_ch;
    logic                  r_a_last;

    logic                  r_b_valid;
    logic [VALUE_SIZE-1:0] r_b_val;
    logic [CH_W-1:0]       r_b_ch;
    logic                  r_b_last;

    logic [VALUE_SIZE-1:0] r_acc [NUM_CH];

    logic                  r_out_valid;
    logic [VALUE_SIZE-1:0] r_psum;
    logic [CH_W-1:0]       r_out_ch;

    logic [VALUE_SIZE-1:0] w_sel;
    logic [VALUE_SIZE-1:0] w_acc_rd;
    logic [VALUE_SIZE-1:0] w_b_sum;
    logic                  w_pend_last;
    logic                  w_stall;
    logic                  w_b_done;
    logic                  w_accept;

    // Lane select: ind=k picks lane k-1; 0 or out-of-range gives +0.
    always_comb begin
        w_sel = FP_POS_ZERO;
        for (int k = 0; k < N; k++) begin
            if (ind == INDEX_SIZE'(k + 1)) begin
                w_sel = val[k*VALUE_SIZE +: VALUE_SIZE];
            end else begin
                w_sel = w_sel;
            end
        end
    end

    // A last word in B cannot retire while the previous result is unread,
    // so the whole pipe freezes; in_ready drops early enough that no word
    // arrives while frozen.
    assign w_pend_last = (r_a_valid && r_a_last) || (r_b_valid && r_b_last);
    assign w_stall     = r_out_valid && !out_ready && r_b_valid && r_b_last;
    assign in_ready    = !clear && !(r_out_valid && !out_ready && w_pend_last);
    assign w_accept    = in_valid && in_ready;
    assign w_b_done    = r_b_valid && !w_stall && !clear;
    assign w_acc_rd    = r_acc[r_b_ch];

    fp32_add_rz u_add (
        .i_a   (w_acc_rd),
        .i_b   (r_b_val),
        .o_sum (w_b_sum)
    );

    // Stage A / stage B pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_val   <= '0;
            r_a_ch    <= '0;
            r_a_last  <= 1'b0;
            r_b_valid <= 1'b0;
            r_b_val   <= '0;
            r_b_ch    <= '0;
            r_b_last  <= 1'b0;
        end else if (clear) begin
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
        end else if (!w_stall) begin
            r_b_valid <= r_a_valid;
            r_b_val   <= r_a_val;
            r_b_ch    <= r_a_ch;
            r_b_last  <= r_a_last;
            r_a_valid <= w_accept;
            if (w_accept) begin
                r_a_val  <= w_sel;
                r_a_ch   <= ch;
                r_a_last <= last;
            end
        end
    end

    // Accumulator bank; B writes back the sum, or +0 after a last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) r_acc[c] <= '0;
        end else if (clear) begin
            for (int c = 0; c < NUM_CH; c++) r_acc[c] <= '0;
        end else if (w_b_done) begin
            r_acc[r_b_ch] <= r_b_last ? FP_POS_ZERO : w_b_sum;
        end
    end

    // Result register: holds until taken, reloads in the taking cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_psum      <= '0;
            r_out_ch    <= '0;
        end else if (w_b_done && r_b_last) begin
            r_out_valid <= 1'b1;
            r_psum      <= w_b_sum;
            r_out_ch    <= r_b_ch;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign psum      = r_psum;
    assign out_ch    = r_out_ch;
    assign busy      = r_b_valid;

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] val;
    logic [6:0]   ind;
    logic [2:0]   ch;
    logic         last;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_ch;
    logic [31:0]  psum;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    logic [31:0] m_acc [8];
    logic [31:0] exp_ps [$];
    logic [2:0]  exp_ch [$];
    logic [31:0] last_psum;
    logic [2:0]  last_ch;
    logic        hold;
    logic [31:0] h_ps;
    logic [2:0]  h_ch;

    psum_accumulator dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .val(val), .ind(ind), .ch(ch), .last(last), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .psum(psum), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: exact sum in double precision, then truncate.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'd0) return 0.0;
        b = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f_rz(input real r);
        logic [63:0] b;
        int e;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        if (e <= 0) return 32'h0;
        if (e >= 255) return {b[63], 8'hFF, 23'd0};
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] gen_val();
        int k;
        int e;
        real r;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 32'h0;
        if (sel == 1) return {1'($urandom_range(0, 1)), 31'h0000_1234};
        k = $urandom_range(1, 4095);
        e = $urandom_range(0, 12) - 6;
        r = real'(k);
        for (int i = 0; i < e; i++) r = r * 2.0;
        for (int i = 0; i > e; i--) r = r / 2.0;
        if ($urandom_range(0, 1) == 1) r = -r;
        return r2f_rz(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model update for a word accepted at the coming edge.
    task automatic model_accept(input logic [2:0] c, input logic [6:0] k,
                                input logic [127:0] v, input logic l);
        logic [31:0] x;
        if (k == 7'd0 || k > 7'd4) x = 32'h0;
        else x = v[(int'(k) - 1) * 32 +: 32];
        m_acc[c] = r2f_rz(f2r(m_acc[c]) + f2r(x));
        if (l) begin
            exp_ps.push_back(m_acc[c]);
            exp_ch.push_back(c);
            m_acc[c] = 32'h0;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] c, input logic [6:0] k,
                        input logic [127:0] v, input logic l);
        int n;
        in_valid = 1'b1; ch = c; ind = k; val = v; last = l;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                errors++;
                $display("FAIL send_timeout: in_ready stuck at %0d for ch %0d", in_ready, c);
                break;
            end
        end
        if (n <= 300) model_accept(c, k, v, l);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_ps.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_ps.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
        for (int c = 0; c < 8; c++) m_acc[c] = 32'h0;
        exp_ps.delete();
        exp_ch.delete();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_psum", psum, 32'h0);
        chk("rst_out_ch", 32'(out_ch), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
    endtask

    // Consumer readiness pattern.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: checks held results and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                checks++;
                if (!(out_valid && psum == h_ps && out_ch == h_ch)) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0d %h ch%0d expected v=1 %h ch%0d",
                             out_valid, psum, out_ch, h_ps, h_ch);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_ps.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %h ch%0d expected none", psum, out_ch);
                end else begin
                    if (psum !== exp_ps[0] || out_ch !== exp_ch[0]) begin
                        errors++;
                        $display("FAIL result: got %h ch%0d expected %h ch%0d",
                                 psum, out_ch, exp_ps[0], exp_ch[0]);
                    end
                    void'(exp_ps.pop_front());
                    void'(exp_ch.pop_front());
                end
                last_psum = psum;
                last_ch   = out_ch;
                hold = 1'b0;
            end else if (out_valid) begin
                hold = 1'b1;
                h_ps = psum;
                h_ch = out_ch;
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0; val = '0; ind = '0; ch = '0; last = 1'b0;
        clear = 1'b0; out_ready = 1'b1; hold = 1'b0;
        last_psum = '0; last_ch = '0;
        @(posedge clk); #1;
        do_reset();

        // Two-word sum on ch 0 with latency and busy checks.
        send(3'd0, 7'd1, {96'd0, 32'h3F80_0000}, 1'b0);
        send(3'd0, 7'd2, {64'd0, 32'h4000_0000, 32'h0}, 1'b1);
        @(posedge clk); #1;
        chk("lat_t1_out_valid", 32'(out_valid), 32'h0);
        chk("lat_t1_busy", 32'(busy), 32'h1);
        @(posedge clk); #1;
        chk("lat_t2_out_valid", 32'(out_valid), 32'h1);
        chk("lat_t2_psum", psum, 32'h4040_0000);
        chk("lat_t2_out_ch", 32'(out_ch), 32'h0);
        drain();

        // Exact cancellation, then the channel restarts from +0.
        send(3'd3, 7'd1, {96'd0, 32'h3FC0_0000}, 1'b0);
        send(3'd3, 7'd1, {96'd0, 32'hBFC0_0000}, 1'b1);
        drain();
        chk("cancel_psum", last_psum, 32'h0);
        send(3'd3, 7'd1, {96'd0, 32'h4000_0000}, 1'b1);
        drain();
        chk("cancel_restart", last_psum, 32'h4000_0000);

        // ind=0 and ind beyond N contribute +0.
        send(3'd1, 7'd1, {96'd0, 32'h40A0_0000}, 1'b0);
        send(3'd1, 7'd0, {32'h1, 32'h2, 32'h3, 32'h4}, 1'b1);
        drain();
        chk("ind0_psum", last_psum, 32'h40A0_0000);
        send(3'd6, 7'd4, {32'h4000_0000, 96'd0}, 1'b0);
        send(3'd6, 7'd7, {32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000}, 1'b1);
        drain();
        chk("ind_range_psum", last_psum, 32'h4000_0000);

        // Overflow to infinity and underflow to +0.
        send(3'd5, 7'd1, {96'd0, 32'h7F00_0000}, 1'b0);
        send(3'd5, 7'd1, {96'd0, 32'h7F00_0000}, 1'b1);
        send(3'd2, 7'd1, {96'd0, 32'hFF00_0000}, 1'b0);
        send(3'd2, 7'd1, {96'd0, 32'hFF00_0000}, 1'b1);
        send(3'd4, 7'd1, {96'd0, 32'h0080_0001}, 1'b0);
        send(3'd4, 7'd1, {96'd0, 32'h8080_0000}, 1'b1);
        drain();
        chk("underflow_psum", last_psum, 32'h0);

        // Interleaved channels with no bubbles.
        for (int i = 0; i < 4; i++) begin
            send(3'd0, 7'd1, {96'd0, 32'h3F80_0000}, i == 3);
            send(3'd1, 7'd1, {96'd0, 32'h3F80_0000}, i == 3);
        end
        drain();
        chk("interleave_last_ch", 32'(last_ch), 32'h1);
        chk("interleave_psum", last_psum, 32'h4080_0000);

        // Back-pressure with two last words pending.
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send(3'd0, 7'd1, {96'd0, 32'h3F80_0000}, 1'b1);
        send(3'd1, 7'd1, {96'd0, 32'h4000_0000}, 1'b1);
        repeat (4) @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'h0);
        chk("stall_out_valid", 32'(out_valid), 32'h1);
        chk("stall_psum", psum, 32'h3F80_0000);
        chk("stall_busy", 32'(busy), 32'h1);
        @(posedge clk); #1;
        rdy_mode = 0;
        drain();
        chk("stall_release_psum", last_psum, 32'h4000_0000);

        // Clear with a result pending, then every channel reads back +0.
        rdy_mode = 2;
        send(3'd2, 7'd1, {96'd0, 32'h4040_0000}, 1'b1);
        for (int c = 0; c < 8; c++) send(3'(c), 7'd1, {96'd0, 32'h4100_0000}, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        clear = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 8; c++) m_acc[c] = 32'h0;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_keeps_result", 32'(out_valid), 32'h1);
        rdy_mode = 0;
        for (int c = 0; c < 8; c++) send(3'(c), 7'd1, {96'd0, 32'h3FC0_0000}, 1'b1);
        drain();

        // Reset mid-stream with words in flight and a result unread.
        rdy_mode = 2;
        send(3'd4, 7'd1, {96'd0, 32'h4100_0000}, 1'b0);
        send(3'd4, 7'd1, {96'd0, 32'h4100_0000}, 1'b1);
        send(3'd5, 7'd1, {96'd0, 32'h4100_0000}, 1'b0);
        do_reset();
        rdy_mode = 0;
        for (int c = 0; c < 8; c++) send(3'(c), 7'd1, {96'd0, 32'h3FC0_0000}, 1'b1);
        drain();

        // Randomized traffic with random consumer readiness.
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send(3'($urandom_range(0, 7)), 7'($urandom_range(0, 6)),
                 {gen_val(), gen_val(), gen_val(), gen_val()},
                 ($urandom_range(0, 3) == 0));
        end
        for (int c = 0; c < 8; c++) send(3'(c), 7'd0, 128'd0, 1'b1);
        rdy_mode = 0;
        drain();
        chk("scoreboard_empty", 32'(exp_ps.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
